dmem_lsu: RTL and testbench

- CPU-side initiator that drives the data-memory controller port (addr/datain/memop/we, consumes dataout) on behalf of the core's load/store stage.
- Accepts one request at a time over a valid/ready handshake.
- Sequences the synchronous-read latency and the multi-cycle write hold required by the byte-enable RAM.
- Splits word-crossing misaligned accesses into byte beats, so the memory controller only ever sees accesses it can complete.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/lsu_load_merge.sv | 32 +++
 rtl/dmem_lsu.sv | 129 ++++++++++++
 tb/tb_dmem_lsu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: memop encodings, LSU state type and request classification helpers
package dmem_pkg;
    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;
    localparam logic [2:0] MEMOP_SB  = 3'b000;

    typedef enum logic [1:0] {IDLE, ACC, CAP, RESP} lsu_state_t;

    // Access size in bytes; 0 marks the illegal encoding 11
    function automatic logic [2:0] op_size(input logic [2:0] op);
        return op[1:0] == 2'b00 ? 3'd1 : op[1:0] == 2'b01 ? 3'd2 : op[1:0] == 2'b10 ? 3'd4 : 3'd0;
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        return (op_size(op) == 3'd2 && a == 2'b11) || (op_size(op) == 3'd4 && a != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_load_merge.sv
// lsu_load_merge: assembles split-load bytes little-endian and extends the result to 32 bits
module lsu_load_merge
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        cap,
    input  logic        split,
    input  logic [1:0]  beat,
    input  logic [2:0]  memop,
    input  logic [31:0] din,
    output logic [31:0] rdata
);
    logic [31:0] asm_q, asm_d;

    always_comb begin
        asm_d = asm_q;
        if (clr) asm_d = '0;
        else if (cap && split) asm_d[8*beat +: 8] = din[7:0];
        else if (cap) asm_d = din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) asm_q <= '0;
        else asm_q <= asm_d;
    end

    // Aligned words pass through untouched; only split halfwords need extending
    assign rdata = (!split || op_size(memop) == 3'd4) ? asm_q :
                   memop[2] ? {16'h0, asm_q[15:0]} : {{16{asm_q[15]}}, asm_q[15:0]};
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for the byte-enable data RAM controller,
// sequencing read latency, write hold and byte-beat splitting of misaligned accesses.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1,
    parameter int WR_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_memop,
    input  logic [17:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [17:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic [2:0]  mem_memop,
    output logic        mem_we,
    input  logic [31:0] mem_dataout
);
    lsu_state_t  state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [7:0]  hold_q, hold_d;
    logic        we_q, split_q, err_q;
    logic [2:0]  memop_q;
    logic [17:0] addr_q;
    logic [31:0] wdata_q;
    logic [17:0] mem_addr_q;
    logic [2:0]  mem_memop_q;
    logic [31:0] mem_datain_q;
    logic        accept, advance, last, req_mis, req_err;
    logic [31:0] merged;

    assign req_mis = misaligned(req_memop, req_addr[1:0]);
    assign req_err = op_size(req_memop) == 3'd0 || (req_mis && !SPLIT_EN);
    assign accept  = state_q == IDLE && req_valid;
    assign last    = !split_q || beat_q == 2'(op_size(memop_q) - 3'd1);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        hold_d  = hold_q;
        advance = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = req_err ? RESP : ACC;
                beat_d  = '0;
                hold_d  = '0;
            end
            ACC: if (!we_q) state_d = CAP;
                else if (hold_q != 8'(WR_HOLD - 1)) hold_d = hold_q + 8'd1;
                else begin
                    hold_d  = '0;
                    state_d = last ? RESP : ACC;
                    advance = !last;
                end
            CAP: begin
                state_d = last ? RESP : ACC;
                advance = !last;
            end
            default: state_d = IDLE;
        endcase
        if (advance) beat_d = beat_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            hold_q       <= '0;
            we_q         <= 1'b0;
            split_q      <= 1'b0;
            err_q        <= 1'b0;
            memop_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_memop_q  <= '0;
            mem_datain_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
            if (accept) begin
                we_q    <= req_we;
                memop_q <= req_memop;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                split_q <= req_mis && SPLIT_EN;
                err_q   <= req_err;
            end
            // Errored requests never touch the memory port, so its outputs keep their old value
            if (accept && !req_err) begin
                mem_addr_q   <= req_addr;
                mem_memop_q  <= (req_mis && SPLIT_EN) ? (req_we ? MEMOP_SB : MEMOP_LBU) : req_memop;
                mem_datain_q <= req_wdata;
            end else if (advance) begin
                mem_addr_q   <= addr_q + 18'(beat_d);
                mem_datain_q <= wdata_q >> {beat_d, 3'b000};
            end
        end
    end

    lsu_load_merge u_merge (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .cap   (state_q == CAP),
        .split (split_q),
        .beat  (beat_q),
        .memop (memop_q),
        .din   (mem_dataout),
        .rdata (merged)
    );

    assign req_ready  = state_q == IDLE && !rst;
    assign resp_valid = state_q == RESP;
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !we_q) ? merged : '0;
    assign mem_we     = state_q == ACC && we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_memop  = mem_memop_q;
    assign mem_datain = mem_datain_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed scoreboard bench for dmem_lsu with a byte-enable RAM model
module tb_dmem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rv0, rv1, req_we;
    logic [2:0]  req_memop;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        rdy0, val0, err0, mwe0, rdy1, val1, err1, mwe1;
    logic [31:0] rdata0, mdin0, mdout0, rdata1, mdin1, mdout1;
    logic [17:0] maddr0, maddr1;
    logic [2:0]  mop0, mop1;

    dmem_lsu #(.SPLIT_EN(1'b1), .WR_HOLD(2)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_we(req_we),
        .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(val0), .resp_rdata(rdata0), .resp_err(err0),
        .mem_addr(maddr0), .mem_datain(mdin0), .mem_memop(mop0), .mem_we(mwe0), .mem_dataout(mdout0)
    );

    dmem_lsu #(.SPLIT_EN(1'b0), .WR_HOLD(2)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_we(req_we),
        .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(val1), .resp_rdata(rdata1), .resp_err(err1),
        .mem_addr(maddr1), .mem_datain(mdin1), .mem_memop(mop1), .mem_we(mwe1), .mem_dataout(mdout1)
    );

    assign mdout1 = 32'h12345678;

    logic [31:0] mem [0:65535];

    function automatic logic [31:0] rd(input logic [17:0] a, input logic [2:0] op);
        logic [31:0] w;
        w = mem[a[17:2]] >> (8 * a[1:0]);
        return op[1:0] == 2'b00 ? (op[2] ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]}) :
               op[1:0] == 2'b01 ? (op[2] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]}) : w;
    endfunction

    function automatic logic [31:0] wr(input logic [31:0] w, input logic [1:0] a, input logic [2:0] op, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (op[1:0] == 2'b00) r[8*a +: 8] = d[7:0];
        else if (op[1:0] == 2'b01) r[8*a +: 16] = d[15:0];
        else r = d;
        return r;
    endfunction

    always @(posedge clk) begin
        mdout0 <= rd(maddr0, mop0);
        if (mwe0) mem[maddr0[17:2]] <= wr(mem[maddr0[17:2]], maddr0[1:0], mop0, mdin0);
    end

    logic        sel;
    logic        s_valid, s_err, s_we, s_ready;
    logic [31:0] s_rdata;
    logic [17:0] s_addr;
    logic [2:0]  s_op;
    assign s_valid = sel ? val1 : val0;
    assign s_err   = sel ? err1 : err0;
    assign s_we    = sel ? mwe1 : mwe0;
    assign s_ready = sel ? rdy1 : rdy0;
    assign s_rdata = sel ? rdata1 : rdata0;
    assign s_addr  = sel ? maddr1 : maddr0;
    assign s_op    = sel ? mop1 : mop0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [17:0] alog [0:63];
    logic [2:0]  olog [0:63];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic s, input logic we, input logic [2:0] op, input logic [17:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat, input int wes, input string tag);
        int   n;
        int   wc;
        exp_t e;
        sel = s;
        @(negedge clk);
        req_we = we;
        req_memop = op;
        req_addr = a;
        req_wdata = wd;
        if (s) rv1 = 1'b1;
        else rv0 = 1'b1;
        e = '{er, ee};
        sb.push_back(e);
        chk({tag, "_ready"}, {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        rv0 = 1'b0;
        rv1 = 1'b0;
        n = 1;
        wc = 0;
        while (!s_valid && n < 63) begin
            alog[n] = s_addr;
            olog[n] = s_op;
            wc += int'(s_we);
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_wecnt"}, 32'(wc), 32'(wes));
        e = sb.pop_front();
        chk({tag, "_rdata"}, s_rdata, e.rdata);
        chk({tag, "_err"}, {31'b0, s_err}, {31'b0, e.err});
    endtask

    initial begin
        int vcnt;
        sel = 1'b0;
        rv0 = 1'b0;
        rv1 = 1'b0;
        req_we = 1'b0;
        req_memop = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < 65536; i++) mem[i] <= '0;
        mem[0] <= 32'h44332211;
        mem[1] <= 32'h88776655;
        mem[2] <= 32'h000000AA;
        mem[16'hFFFF] <= 32'h80000000;
        repeat (2) @(negedge clk);
        chk("rst_ready0", {31'b0, rdy0}, 32'd0);
        chk("rst_ready1", {31'b0, rdy1}, 32'd0);
        chk("rst_valid", {30'b0, val0, val1}, 32'd0);
        chk("rst_err", {30'b0, err0, err1}, 32'd0);
        chk("rst_rdata", rdata0 | rdata1, 32'd0);
        chk("rst_we", {30'b0, mwe0, mwe1}, 32'd0);
        chk("rst_addr", {14'b0, maddr0 | maddr1}, 32'd0);
        chk("rst_memop", {29'b0, mop0 | mop1}, 32'd0);
        chk("rst_datain", mdin0 | mdin1, 32'd0);
        rst = 1'b0;

        xact(0, 0, 3'b010, 18'h00000, 0, 32'h44332211, 0, 3, 0, "lw0");
        xact(0, 0, 3'b010, 18'h00003, 0, 32'h77665544, 0, 9, 0, "lw3");
        for (int k = 0; k < 4; k++) begin
            chk("lw3_beat_addr", {14'b0, alog[2*k+1]}, 32'(3 + k));
            chk("lw3_beat_op", {29'b0, olog[2*k+1]}, 32'b100);
        end
        xact(0, 0, 3'b001, 18'h00007, 0, 32'hFFFFAA88, 0, 5, 0, "lh7");
        xact(0, 0, 3'b101, 18'h00007, 0, 32'h0000AA88, 0, 5, 0, "lhu7");
        xact(0, 0, 3'b001, 18'h00001, 0, 32'h00003322, 0, 3, 0, "lh1");
        xact(0, 0, 3'b001, 18'h3FFFF, 0, 32'h00001180, 0, 5, 0, "lhwrap");
        chk("lhwrap_addr", {14'b0, alog[3]}, 32'd0);
        xact(0, 1, 3'b010, 18'h00001, 32'hDEADBEEF, 0, 0, 9, 8, "sw1");
        xact(0, 0, 3'b010, 18'h00000, 0, 32'hADBEEF11, 0, 3, 0, "lw0b");
        xact(0, 0, 3'b010, 18'h00004, 0, 32'h887766DE, 0, 3, 0, "lw4");
        xact(0, 1, 3'b010, 18'h00008, 32'hCAFEF00D, 0, 0, 3, 2, "sw8");
        xact(0, 0, 3'b010, 18'h00008, 0, 32'hCAFEF00D, 0, 3, 0, "lw8");
        xact(0, 0, 3'b011, 18'h00000, 0, 0, 1, 1, 0, "op11_s1");

        xact(1, 0, 3'b010, 18'h00008, 0, 32'h12345678, 0, 3, 0, "u1_lw8");
        xact(1, 0, 3'b010, 18'h00002, 0, 0, 1, 1, 0, "u1_lw2");
        chk("u1_addr_kept", {14'b0, maddr1}, 32'h8);
        xact(1, 0, 3'b011, 18'h00000, 0, 0, 1, 1, 0, "op11_s0");

        sel = 1'b0;
        @(negedge clk);
        req_we = 1'b1;
        req_memop = 3'b010;
        req_addr = 18'h00001;
        req_wdata = 32'h01020304;
        rv0 = 1'b1;
        @(negedge clk);
        rv0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_we_before", {31'b0, mwe0}, 32'd1);
        chk("abort_beat2_addr", {14'b0, maddr0}, 32'h2);
        rst = 1'b1;
        #1;
        chk("abort_we_async", {31'b0, mwe0}, 32'd0);
        chk("abort_ready_in_rst", {31'b0, rdy0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", {31'b0, rdy0}, 32'd1);
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vcnt += int'(val0);
        end
        chk("abort_no_resp", 32'(vcnt), 32'd0);
        xact(0, 0, 3'b010, 18'h00000, 0, 32'hADBE0411, 0, 3, 0, "lw_after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
